// File: rtl/bin2bcd_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq_pkg
// Brief    : Shared widths, FSM encodings and helpers for the BCD converter.
// Revision : 1.0
// ============================================================================
package bin2bcd_seq_pkg;

    localparam int c_bin_w  = 10;
    localparam int c_digits = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_adj
// Brief    : Double-dabble digit correction: add 3 when the digit is >= 5.
// Revision : 1.0
// ============================================================================
module bcd_digit_adj (
    input  logic [3:0] d_in,
    output logic [3:0] d_out
);

    assign d_out = (d_in >= 4'd5) ? (d_in + 4'd3) : d_in;

endmodule
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Brief    : Sequential double-dabble binary to packed BCD with blank mask.
// Revision : 1.0
// ============================================================================
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int BIN_W  = c_bin_w,
    parameter int DIGITS = c_digits
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank
);

    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    generate
        if (!(pow10(DIGITS) > ((64'd1 << BIN_W) - 64'd1))) begin : g_param_check
            $error("bin2bcd_seq: DIGITS too small to hold 2^BIN_W-1");
        end
    endgenerate

    state_t                 r_state;
    state_t                 w_state_next;
    logic [BIN_W-1:0]       r_sh_bin;
    logic [4*DIGITS-1:0]    r_sh_bcd;
    logic [CNT_W-1:0]       r_cnt;
    logic [4*DIGITS-1:0]    r_bcd;
    logic [DIGITS-1:0]      r_blank;

    logic [4*DIGITS-1:0]    w_adj;
    logic [4*DIGITS-1:0]    w_bcd_next;
    logic [BIN_W-1:0]       w_bin_next;
    logic [DIGITS-1:0]      w_blank;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .d_in  (r_sh_bcd[4*gi +: 4]),
                .d_out (w_adj[4*gi +: 4])
            );
        end
    endgenerate

    assign {w_bcd_next, w_bin_next} = {w_adj, r_sh_bin} << 1;

    // A digit blanks only when it and every more-significant digit are zero.
    always_comb begin
        logic v_zero_above;
        w_blank      = '0;
        v_zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            v_zero_above = v_zero_above && (w_bcd_next[4*i +: 4] == 4'd0);
            w_blank[i]   = v_zero_above;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_SHIFT;
            S_SHIFT: if (r_cnt == '0) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_bin <= '0;
            r_sh_bcd <= '0;
            r_cnt    <= '0;
            r_bcd    <= '0;
            r_blank  <= {{(DIGITS-1){1'b1}}, 1'b0};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sh_bin <= bin;
                        r_sh_bcd <= '0;
                        r_cnt    <= CNT_W'(BIN_W - 1);
                    end
                end
                S_SHIFT: begin
                    r_sh_bin <= w_bin_next;
                    r_sh_bcd <= w_bcd_next;
                    if (r_cnt == '0) begin
                        r_bcd   <= w_bcd_next;
                        r_blank <= w_blank;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (r_state != S_IDLE);
    assign done  = (r_state == S_DONE);
    assign bcd   = r_bcd;
    assign blank = r_blank;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin2bcd_seq
// Brief    : Self-checking bench for bin2bcd_seq against a decimal model.
// Revision : 1.0
// ============================================================================
module tb_bin2bcd_seq;

    localparam int BIN_W  = 10;
    localparam int DIGITS = 4;

    logic                clk;
    logic                rst;
    logic                start;
    logic [BIN_W-1:0]    bin;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]   blank;

    int n_tests;
    int n_fail;

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .blank (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal digits by division; no shifting involved.
    function automatic logic [31:0] exp_bcd(input int v);
        logic [31:0] r;
        int          p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Digit i is a leading zero exactly when the value is below 10^i.
    function automatic logic [31:0] exp_blank(input int v);
        logic [31:0] r;
        int          p;
        r = '0;
        p = 10;
        for (int i = 1; i < DIGITS; i++) begin
            r[i] = (v < p);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Entered just after a rising edge; returns just after a rising edge.
    task automatic run_conv(input int v, input bit pulse);
        start = 1'b1;
        bin   = BIN_W'(v);
        @(posedge clk); #1;
        start = 1'b0;
        bin   = BIN_W'($urandom_range(0, 1023));
        for (int cyc = 1; cyc <= BIN_W + 1; cyc++) begin
            start = pulse && (cyc == 2 || cyc == BIN_W + 1);
            @(negedge clk);
            check("busy_conv", 32'(busy), 32'd1);
            check("done_conv", 32'(done), 32'(cyc == BIN_W + 1));
            if (cyc == BIN_W + 1) begin
                check("bcd", 32'(bcd), exp_bcd(v));
                check("blank", 32'(blank), exp_blank(v));
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(negedge clk);
        check("busy_after", 32'(busy), 32'd0);
        check("done_after", 32'(done), 32'd0);
        check("bcd_hold", 32'(bcd), exp_bcd(v));
        @(posedge clk); #1;
    endtask

    initial begin
        int dir_vals[6];
        n_tests = 0;
        n_fail  = 0;
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_blank", 32'(blank), 32'b1110);
        rst = 1'b0;
        @(posedge clk); #1;

        dir_vals = '{0, 1023, 510, 99, 100, 9};
        foreach (dir_vals[k]) run_conv(dir_vals[k], 1'b0);

        // Stray start pulses while busy, including in the done cycle.
        run_conv(421, 1'b1);

        // Held start with bin changed mid-conversion.
        start = 1'b1;
        bin   = BIN_W'(7);
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= 2 * (BIN_W + 2) - 1; cyc++) begin
            if (cyc == 3) bin = BIN_W'(999);
            @(negedge clk);
            check("held_busy", 32'(busy), 32'(cyc != BIN_W + 2));
            check("held_done", 32'(done), 32'(cyc == BIN_W + 1 || cyc == 2 * BIN_W + 3));
            if (cyc == BIN_W + 1) begin
                check("held_bcd1", 32'(bcd), exp_bcd(7));
                check("held_blank1", 32'(blank), exp_blank(7));
            end
            if (cyc == 2 * BIN_W + 3) begin
                check("held_bcd2", 32'(bcd), exp_bcd(999));
                check("held_blank2", 32'(blank), exp_blank(999));
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a conversion.
        start = 1'b1;
        bin   = BIN_W'(345);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bcd", 32'(bcd), 32'd0);
        check("abort_blank", 32'(blank), 32'b1110);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
            check("abort_idle", 32'(busy), 32'd0);
            @(posedge clk); #1;
        end
        run_conv(345, 1'b0);

        for (int k = 0; k < 20; k++) begin
            run_conv(int'($urandom_range(0, 1023)), 1'(k % 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential double-dabble converter between the calculator's result stage and the seven-segment display path.
- Accepts the unsigned binary answer (up to 10 bits, 0..1023) on a start strobe.
- Produces four packed BCD digits plus a leading-zero blank mask after a fixed number of cycles.
- The display handler consumes these in place of raw hex nibbles.

Parameters:
- BIN_W, 10: width of binary input.
- DIGITS, 4: number of BCD output digits. Elaboration fails unless 10^DIGITS > 2^BIN_W - 1.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request conversion; sampled only when busy=0.
- bin  input  BIN_W  unsigned value; captured on the accepting edge.
- busy  output  1  high from the cycle after acceptance until done completes.
- done  output  1  one-cycle pulse; bcd/blank valid from this cycle.
- bcd  output  4*DIGITS  packed BCD; digit 0 in [3:0], ones.
- blank  output  DIGITS  bit i=1 means digit i is a leading zero. Bit 0 is always 0.

Behaviour:
- Reset (async, rst=1): state IDLE, busy=0, done=0, bcd=0, blank={DIGITS-1{1},0}, internal shift/count registers cleared.
- Reset mid-conversion aborts the conversion. No done is issued and no partial result reaches bcd.
- States, encoded in the package:
  - IDLE: busy=0. On an edge with start=1, load sh_bin<=bin, sh_bcd<=0, cnt<=BIN_W-1, go to SHIFT.
  - SHIFT: busy=1. Each cycle, every 4-bit digit of sh_bcd that is >=5 gets +3. Then {sh_bcd,sh_bin} shifts left by 1. cnt decrements. When cnt==0 the final adjust+shift result is written to bcd, blank is computed from it, and the state goes to DONE.
  - DONE: busy=1, done=1 for exactly this one cycle. Unconditional return to IDLE.
- Latency: start sampled at edge E0 → SHIFT occupies cycles 1..BIN_W → done=1 in cycle BIN_W+1 (cycle 11 for default).
- Throughput: with start held high, a new conversion is accepted every BIN_W+2 cycles.
- start while busy=1, including in DONE, is ignored (no queueing).
- bin changes after the accepting edge have no effect on the current conversion.
- bcd and blank are registered outputs. They change only on the edge that raises done and hold until the next done.
- Blank rule: bit i (i>=1) is 1 iff digits i..DIGITS-1 are all zero. Digit 0 always displays, so value 0 shows "0".
- Adjust arithmetic is 4-bit unsigned. Inputs 5..9 map to 8..12 before the shift. Values >9 never occur for legal inputs.
- done and busy never both low while the state is not IDLE.

Decomposition:
- Shared calc package holds:
  - state encodings S_IDLE=2'b00, S_SHIFT=2'b01, S_DONE=2'b10;
  - default BIN_W/DIGITS constants, so the display handler uses the same widths.
- One combinational sub-module, bcd_digit_adj (4-bit in → 4-bit out, +3 if >=5), instantiated DIGITS times in a generate loop.
- Blank-mask logic is inline.

Test Plan:
- Reset, then start with bin=0 → busy=1 cycles 1..11, done=1 in cycle 11 only; bcd=16'h0000, blank=4'b1110.
- bin=1023 → bcd=16'h1023, blank=4'b0000. Also bin=510 (max SUM) → bcd=16'h0510, blank=4'b1000.
- Boundaries: bin=99 → 16'h0099, blank 4'b1100; bin=100 → 16'h0100, blank 4'b1000; bin=9 → 16'h0009, blank 4'b1110.
- start held high, bin=7, bin switched to 999 in cycle 3 → first done gives 0007 (change ignored); the next acceptance is 12 cycles after the first and gives 0999, blank 4'b1000.
- start pulse during busy (cycles 2 and 11) → no extra conversion, done pulses once.
- Convert 345, assert rst in cycle 5 → busy/done drop immediately, bcd=0, blank=4'b1110, no done follows. After release, start 345 → bcd=16'h0345, blank=4'b1000.
